// File: rtl/peri_bus_pkg.sv
// Shared types and constants for the peripheral config bus initiator and the DRA responder map.
package peri_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RSP  = 2'd3
   } state_e;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } cmd_t;

   localparam int          CMD_W             = $bits(cmd_t);
   localparam logic [31:0] PERI_TIMEOUT_DATA = 32'hDEADBEEF;
   localparam logic [15:0] DRA_GUARD_KEY     = 16'h1234;
   localparam logic [31:0] DRA_OFF_GUARD     = 32'h0;
   localparam logic [31:0] DRA_OFF_START     = 32'h4;
   localparam logic [31:0] DRA_OFF_RESET     = 32'h8;

endpackage

// File: rtl/peri_cmd_initiator_if.sv
// Single-access peripheral config bus: strobes plus held address/data, one-cycle ready from the responder.
interface peri_cmd_initiator_if;
   logic        rden;
   logic        wren;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        ready;

   modport master (output rden, wren, addr, wdata, wstrb, input rdata, ready);
   modport slave  (input rden, wren, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/peri_cmd_fifo.sv
// Command FIFO: one-cycle write latency, extra pointer bit distinguishes full from empty.
module peri_cmd_fifo #(
   parameter int WIDTH = 69,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   output logic             o_full,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign o_empty = (wr_ptr_q == rd_ptr_q);
   assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // A pop in the same cycle does not make room for a push on full.
   assign do_push = i_push & ~o_full;
   assign do_pop  = i_pop & ~o_empty;
   assign o_dout  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_din;
   end
endmodule

// File: rtl/peri_cmd_initiator.sv
// Queued read/write command initiator for the peripheral config bus, one access in flight.
// Optional WAIT timeout with error response enabled by defining PERI_INIT_TIMEOUT_EN.
module peri_cmd_initiator
   import peri_bus_pkg::*;
#(
   parameter int CMD_DEPTH   = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_cmd_valid,
   output logic                        o_cmd_ready,
   input  logic                        i_cmd_wr,
   input  logic [31:0]                 i_cmd_addr,
   input  logic [31:0]                 i_cmd_wdata,
   input  logic [3:0]                  i_cmd_wstrb,
   output logic                        o_rsp_valid,
   input  logic                        i_rsp_ready,
   output logic [31:0]                 o_rsp_rdata,
   output logic                        o_rsp_err,
   peri_cmd_initiator_if.master        peri,
   output logic                        o_busy
);
   if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("CMD_DEPTH must be a power of 2 and >= 2");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be >= 1");
   end

   state_e      state_q, state_d;
   cmd_t        cur_q, cur_d, cmd_in, fifo_dout;
   logic [31:0] rdata_q, rdata_d;
   logic        init_done_q, init_done_d;
   logic        fifo_full, fifo_empty, fifo_pop, push;

`ifdef PERI_INIT_TIMEOUT_EN
   localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   assign o_rsp_err = err_q;
`else
   assign o_rsp_err = 1'b0;
`endif

   assign cmd_in = '{wr: i_cmd_wr, addr: i_cmd_addr, wdata: i_cmd_wdata, wstrb: i_cmd_wstrb};
   // Held low through reset and for the first cycle after release.
   assign o_cmd_ready = init_done_q & ~fifo_full;
   assign push        = i_cmd_valid & o_cmd_ready;

   peri_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push),
      .i_din   (cmd_in),
      .o_full  (fifo_full),
      .i_pop   (fifo_pop),
      .o_dout  (fifo_dout),
      .o_empty (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      rdata_d     = rdata_q;
      init_done_d = 1'b1;
      fifo_pop    = 1'b0;
`ifdef PERI_INIT_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_d       = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               cur_d    = fifo_dout;
               state_d  = ST_REQ;
            end
         end
         ST_REQ: begin
`ifdef PERI_INIT_TIMEOUT_EN
            cnt_d = '0;
`endif
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Ready at the timeout limit still wins as a normal response.
            if (peri.ready) begin
               rdata_d = cur_q.wr ? 32'h0 : peri.rdata;
`ifdef PERI_INIT_TIMEOUT_EN
               err_d   = 1'b0;
`endif
               state_d = ST_RSP;
            end
`ifdef PERI_INIT_TIMEOUT_EN
            else if (cnt_q == TW'(TIMEOUT_CYC)) begin
               rdata_d = PERI_TIMEOUT_DATA;
               err_d   = 1'b1;
               state_d = ST_RSP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         ST_RSP: begin
            if (i_rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         cur_q       <= '0;
         rdata_q     <= '0;
         init_done_q <= 1'b0;
`ifdef PERI_INIT_TIMEOUT_EN
         cnt_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         rdata_q     <= rdata_d;
         init_done_q <= init_done_d;
`ifdef PERI_INIT_TIMEOUT_EN
         cnt_q       <= cnt_d;
         err_q       <= err_d;
`endif
      end
   end

   // Strobes decode straight from state so an async reset drops them at once.
   assign peri.rden  = (state_q == ST_REQ) & ~cur_q.wr;
   assign peri.wren  = (state_q == ST_REQ) &  cur_q.wr;
   assign peri.addr  = cur_q.addr;
   assign peri.wdata = cur_q.wdata;
   assign peri.wstrb = cur_q.wstrb;

   assign o_rsp_valid = (state_q == ST_RSP);
   assign o_rsp_rdata = rdata_q;
   assign o_busy      = ~fifo_empty | (state_q != ST_IDLE);
endmodule
